// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cache to physical-memory arbiter.
// The line width lives here so the caches, the adaptor and the arbiter all agree.
package cache_arbiter_pkg;

  localparam int CACHELINE_W = 256;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_I = 2'd1;
  localparam logic [1:0] ST_GRANT_D = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GRANT_I = ST_GRANT_I,
    GRANT_D = ST_GRANT_D
  } arbiter_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_t;

endpackage

// File: rtl/cache_arbiter.sv
// Round-robin arbiter that shares one line-wide memory port between the
// I-cache and the D-cache, with a one-cycle grant latency and an IDLE bubble.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int LINE_W = CACHELINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [31:0]       i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [31:0]       d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester holds read/write (and address/data) level-high until
  // it sees a one-cycle *_resp pulse; the arbiter holds its grant until mem_resp.
  arbiter_state_t state, next_state;
  arb_side_t      last_grant, next_last_grant;
  logic           i_req, d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= SIDE_I;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
    end
  end

  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = 32'd0;
    mem_wdata       = '0;
    i_pmem_resp     = 1'b0;
    d_pmem_resp     = 1'b0;
    case (state)
      IDLE: begin
        // On contention the side that did not win last time goes first.
        if (i_req && d_req) begin
          if (last_grant == SIDE_I) begin
            next_state      = GRANT_D;
            next_last_grant = SIDE_D;
          end else begin
            next_state      = GRANT_I;
            next_last_grant = SIDE_I;
          end
        end else if (i_req) begin
          next_state      = GRANT_I;
          next_last_grant = SIDE_I;
        end else if (d_req) begin
          next_state      = GRANT_D;
          next_last_grant = SIDE_D;
        end
      end
      GRANT_I: begin
        mem_read    = 1'b1;
        mem_address = i_pmem_address;
        i_pmem_resp = mem_resp;
        if (mem_resp) next_state = IDLE;
      end
      GRANT_D: begin
        mem_read    = d_pmem_read & ~d_pmem_write;
        mem_write   = d_pmem_write;
        mem_address = d_pmem_address;
        mem_wdata   = d_pmem_wdata;
        d_pmem_resp = mem_resp;
        if (mem_resp) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign state_dbg    = state;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: requester and memory models drive the DUT,
// a monitor checks every completed transaction against an expected queue.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  localparam int LINE_W = CACHELINE_W;
  localparam int EW     = 164;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] w;
  } d_req_t;

  logic              clk;
  logic              rst;
  logic              i_pmem_read;
  logic [31:0]       i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [31:0]       d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_address;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;
  logic [1:0]        state_dbg;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   i_q[$];
  d_req_t        d_q[$];

  int   checks = 0;
  int   errors = 0;
  int   lat = 5;
  int   i_resp_cnt = 0;
  int   d_resp_cnt = 0;
  logic drop_all = 1'b0;
  logic spur_on = 1'b0;

  cache_arbiter #(.LINE_W(LINE_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_resp       (mem_resp),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    drop_all = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    drop_all = 1'b0;
  endtask

  // ---------------- helpers ----------------
  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [EW-1:0] mk_i(input logic [31:0] a);
    return {1'b0, 1'b1, 1'b0, 1'b1, a, 64'd0, pat(a), pat(a)};
  endfunction

  function automatic logic [EW-1:0] mk_d(input logic rd, input logic wr,
                                         input logic [31:0] a, input logic [31:0] w);
    return {1'b1, 1'b0, wr, rd & ~wr, a, w, w, pat(a), pat(a)};
  endfunction

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_i(input logic [31:0] a);
    exp_q.push_back(mk_i(a));
    i_q.push_back(a);
  endtask

  task automatic push_d(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] w);
    d_req_t e;
    e.rd = rd; e.wr = wr; e.addr = a; e.w = w;
    exp_q.push_back(mk_d(rd, wr, a, w));
    d_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && i_q.size() == 0 && d_q.size() == 0 &&
          !i_pmem_read && !d_pmem_read && !d_pmem_write) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout, %0d responses still expected", name, exp_q.size());
    exp_q.delete();
  endtask

  // ---------------- driver: requesters ----------------
  initial begin
    int     i_handled;
    int     d_handled;
    d_req_t e;
    i_handled = 0;
    d_handled = 0;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (drop_all) begin
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        i_handled = i_resp_cnt;
        d_handled = d_resp_cnt;
      end else begin
        if (i_handled != i_resp_cnt) begin
          i_pmem_read = 1'b0;
          i_handled = i_resp_cnt;
        end else if (!i_pmem_read && i_q.size() > 0) begin
          i_pmem_address = i_q.pop_front();
          i_pmem_read = 1'b1;
        end
        if (d_handled != d_resp_cnt) begin
          d_pmem_read = 1'b0;
          d_pmem_write = 1'b0;
          d_handled = d_resp_cnt;
        end else if (!d_pmem_read && !d_pmem_write && d_q.size() > 0) begin
          e = d_q.pop_front();
          d_pmem_address = e.addr;
          d_pmem_wdata = {(LINE_W/32){e.w}};
          d_pmem_read = e.rd;
          d_pmem_write = e.wr;
        end
      end
    end
  end

  // ---------------- driver: memory model ----------------
  initial begin
    int cnt;
    cnt = 0;
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (spur_on) begin
        mem_resp = 1'b1;
      end else if (mem_resp) begin
        mem_resp = 1'b0;
        cnt = 0;
      end else if (mem_read || mem_write) begin
        cnt++;
        if (cnt >= lat) begin
          mem_resp = 1'b1;
          mem_rdata = {(LINE_W/32){pat(mem_address)}};
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic          prev_resp;
    logic [EW-1:0] act;
    logic [EW-1:0] e;
    prev_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_resp === 1'b1) begin
        checks++;
        if (mem_read || mem_write || i_pmem_resp || d_pmem_resp) begin
          errors++;
          $display("FAIL idle_bubble: got rd=%b wr=%b iresp=%b dresp=%b expected all 0",
                   mem_read, mem_write, i_pmem_resp, d_pmem_resp);
        end
      end
      if (i_pmem_resp === 1'b1 || d_pmem_resp === 1'b1) begin
        act = {d_pmem_resp, i_pmem_resp, mem_write, mem_read, mem_address,
               d_pmem_resp ? {mem_wdata[LINE_W-1 -: 32], mem_wdata[31:0]} : 64'd0,
               i_pmem_rdata[31:0], d_pmem_rdata[31:0]};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got %h expected no response", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL resp_txn: got %h expected %h", act, e);
          end
        end
        if (i_pmem_resp === 1'b1) i_resp_cnt++;
        if (d_pmem_resp === 1'b1) d_resp_cnt++;
      end
      prev_resp = (i_pmem_resp === 1'b1) || (d_pmem_resp === 1'b1);
    end
  end

  // ---------------- directed tests ----------------
  initial begin
    bit seen;
    rst = 1'b1;

    // Reset state
    do_reset();
    chk("reset_mem_read", LINE_W'(mem_read), '0);
    chk("reset_mem_write", LINE_W'(mem_write), '0);
    chk("reset_mem_address", LINE_W'(mem_address), '0);
    chk("reset_mem_wdata", mem_wdata, '0);
    chk("reset_state", LINE_W'(state_dbg), LINE_W'(ST_IDLE));

    // I-only read at 0x60, memory answers on the 5th grant cycle
    lat = 5;
    push_i(32'h0000_0060);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = i_pmem_read;
    end
    chk("i_req_raised", LINE_W'(seen), LINE_W'(1'b1));
    chk("grant_latency_idle", LINE_W'(mem_read), '0);
    @(negedge clk);
    chk("grant_i_mem_read", LINE_W'(mem_read), LINE_W'(1'b1));
    chk("grant_i_address", LINE_W'(mem_address), LINE_W'(32'h60));
    chk("grant_i_state", LINE_W'(state_dbg), LINE_W'(ST_GRANT_I));
    wait_idle("i_only");
    chk("i_only_back_idle", LINE_W'(state_dbg), LINE_W'(ST_IDLE));

    // Simultaneous I and D right after reset: D first, then I
    do_reset();
    lat = 3;
    push_d(1'b1, 1'b0, 32'h0000_0200, 32'h1111_2222);
    push_i(32'h0000_0300);
    wait_idle("contend_after_reset");

    // D writeback of 0xA5 bytes, then a read+write collision where write wins
    lat = 4;
    push_d(1'b0, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5);
    push_d(1'b1, 1'b1, 32'h0000_1040, 32'h3C3C_3C3C);
    wait_idle("d_write");

    // Four back-to-back contended transactions: D, I, D, I
    do_reset();
    lat = 2;
    push_d(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    push_i(32'h0000_0400);
    push_d(1'b1, 1'b0, 32'h0000_0140, 32'hDEAD_BEEF);
    push_i(32'h0000_0440);
    wait_idle("round_robin");

    // Reset in the middle of a D grant aborts it
    lat = 20;
    d_q.push_back('{rd: 1'b1, wr: 1'b0, addr: 32'h0000_2000, w: 32'h7777_7777});
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = mem_read;
    end
    chk("abort_grant_seen", LINE_W'(seen), LINE_W'(1'b1));
    @(negedge clk);
    do_reset();
    chk("abort_mem_read", LINE_W'(mem_read), '0);
    chk("abort_mem_write", LINE_W'(mem_write), '0);
    chk("abort_mem_address", LINE_W'(mem_address), '0);
    chk("abort_mem_wdata", mem_wdata, '0);
    chk("abort_d_resp", LINE_W'(d_pmem_resp), '0);
    chk("abort_state", LINE_W'(state_dbg), LINE_W'(ST_IDLE));
    @(negedge clk);
    chk("abort_still_idle", LINE_W'(mem_read), '0);
    lat = 5;

    // Spurious mem_resp while IDLE
    spur_on = 1'b1;
    @(negedge clk);
    chk("spur_mem_resp_driven", LINE_W'(mem_resp), LINE_W'(1'b1));
    chk("spur_i_resp", LINE_W'(i_pmem_resp), '0);
    chk("spur_d_resp", LINE_W'(d_pmem_resp), '0);
    spur_on = 1'b0;
    @(negedge clk);
    chk("spur_state", LINE_W'(state_dbg), LINE_W'(ST_IDLE));
    chk("spur_mem_read", LINE_W'(mem_read), '0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", LINE_W'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
